// File: rtl/can_reg_arbiter.sv
// can_reg_arbiter: round-robin share of one CAN register bank
// between two host ports, one transaction in flight at a time.
module can_reg_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  reg_cs,
  output logic                  reg_we,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    DONE
  } state_t;

  state_t                r_state;
  logic                  r_last;
  logic                  r_win;
  logic                  r_we;
  logic                  r_cs;
  logic                  r_reg_we;
  logic                  r_ack0;
  logic                  r_ack1;
  logic                  r_busy;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;

  logic                  w_any;
  logic                  w_pick;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;

  // Winner: the lone requester, or on a tie the port
  // that did not win last time.
  assign w_any   = req0 | req1;
  assign w_pick  = (req0 & req1) ? ~r_last : req1;
  assign w_we    = w_pick ? we1    : we0;
  assign w_addr  = w_pick ? addr1  : addr0;
  assign w_wdata = w_pick ? wdata1 : wdata0;

  // Transaction sequencer; every output is a flop set here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_last   <= 1'b1;
      r_win    <= 1'b0;
      r_we     <= 1'b0;
      r_cs     <= 1'b0;
      r_reg_we <= 1'b0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_busy   <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_win    <= w_pick;
            r_we     <= w_we;
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
            r_cs     <= 1'b1;
            r_reg_we <= w_we;
            r_busy   <= 1'b1;
            r_state  <= ACCESS;
          end
        end
        ACCESS: begin
          r_cs     <= 1'b0;
          r_reg_we <= 1'b0;
          if (r_we) begin
            r_ack0  <= ~r_win;
            r_ack1  <= r_win;
            r_state <= DONE;
          end else begin
            r_state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (r_win) begin
            r_rdata1 <= reg_rdata;
          end else begin
            r_rdata0 <= reg_rdata;
          end
          r_ack0  <= ~r_win;
          r_ack1  <= r_win;
          r_state <= DONE;
        end
        DONE: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_last  <= r_win;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign reg_cs    = r_cs;
  assign reg_we    = r_reg_we;
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_can_reg_arbiter.sv
// tb_can_reg_arbiter: table vectors plus corner sequences,
// checked through a transaction scoreboard.
module tb_can_reg_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, we0, req1, we1;
  logic [7:0] addr0, wdata0, addr1, wdata1;
  logic       ack0, ack1;
  logic [7:0] rdata0, rdata1;
  logic       reg_cs, reg_we;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       busy;

  can_reg_arbiter #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req0(req0),
    .we0(we0),
    .addr0(addr0),
    .wdata0(wdata0),
    .req1(req1),
    .we1(we1),
    .addr1(addr1),
    .wdata1(wdata1),
    .ack0(ack0),
    .ack1(ack1),
    .rdata0(rdata0),
    .rdata1(rdata1),
    .reg_cs(reg_cs),
    .reg_we(reg_we),
    .reg_addr(reg_addr),
    .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         p;
    bit         w;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] r;
  } sb_t;

  typedef struct {
    bit         p;
    bit         w;
    logic [7:0] a;
    logic [7:0] d;
    bit         pre;
    logic [7:0] pv;
    logic [7:0] er;
  } vec_t;

  sb_t        q[$];
  vec_t       vt[10];
  logic [7:0] mem[256];
  logic [7:0] mdl[2];
  int         cmp = 0;
  int         err = 0;
  int         cyc = 0;
  int         cs_cnt = 0;

  task automatic chk(input string n, input int act, input int exp);
    cmp++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cyc %0d)",
               n, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Register bank: read data appears the cycle after reg_cs.
  always @(posedge clk) begin
    if (reg_cs && reg_we) mem[reg_addr] <= reg_wdata;
    reg_rdata <= (reg_cs && !reg_we) ? mem[reg_addr] : 8'hEE;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    sb_t e;
    if (reg_we) chk("we_needs_cs", reg_cs, 1);
    if (reg_cs) begin
      cs_cnt++;
      if (q.size() == 0) begin
        chk("cs_unexpected", q.size(), 1);
      end else begin
        chk("cs_we", reg_we, q[0].w);
        chk("cs_addr", reg_addr, q[0].a);
        if (q[0].w) chk("cs_wdata", reg_wdata, q[0].d);
      end
    end
    if (ack0 || ack1) begin
      chk("ack_excl", ack0 & ack1, 0);
      if (q.size() == 0) begin
        chk("ack_unexpected", q.size(), 1);
      end else begin
        e = q.pop_front();
        chk("ack_port", ack1, e.p);
        if (!e.w) begin
          chk("rdata", e.p ? rdata1 : rdata0, e.r);
          mdl[e.p] = e.r;
        end else begin
          chk("rdata_hold", e.p ? rdata1 : rdata0, mdl[e.p]);
        end
      end
    end
  end

  task automatic drive(input bit p, input bit r, input bit w,
                       input logic [7:0] a, input logic [7:0] d);
    if (p) begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end else begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end
  endtask

  task automatic set_req(input bit p, input bit r);
    if (p) req1 = r;
    else   req0 = r;
  endtask

  task automatic push(input bit p, input bit w, input logic [7:0] a,
                      input logic [7:0] d, input logic [7:0] r);
    sb_t e;
    e.p = p; e.w = w; e.a = a; e.d = d; e.r = r;
    q.push_back(e);
  endtask

  task automatic chk_rst();
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_cs", reg_cs, 0);
    chk("rst_we", reg_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", reg_addr, 0);
    chk("rst_wdata", reg_wdata, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
  endtask

  task automatic rst_dut();
    @(posedge clk); #1;
    rst = 1'b1;
    q.delete();
    mdl[0] = 8'h00;
    mdl[1] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_rst();
    rst = 1'b0;
  endtask

  task automatic do_txn(input vec_t v, input bit drop_early);
    int csk, ak;
    @(posedge clk); #1;
    if (v.pre) mem[v.a] = v.pv;
    push(v.p, v.w, v.a, v.d, v.er);
    drive(v.p, 1'b1, v.w, v.a, v.d);
    csk = -1;
    ak  = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("busy", busy, int'(k > 1));
      if (reg_cs) begin
        csk = k;
        if (drop_early) set_req(v.p, 1'b0);
      end
      if (v.p ? ack1 : ack0) begin
        ak = k;
        break;
      end
    end
    set_req(v.p, 1'b0);
    chk("cs_latency", csk, 2);
    chk("ack_latency", ak, v.w ? 3 : 4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, seen, got;
    int t[3];
    int base;
    vec_t v;

    vt[0] = '{0, 1, 8'h04, 8'hA5, 0, 8'h00, 8'h00};
    vt[1] = '{1, 0, 8'h11, 8'hDE, 1, 8'h3C, 8'h3C};
    vt[2] = '{1, 1, 8'h20, 8'h77, 0, 8'h00, 8'h00};
    vt[3] = '{0, 0, 8'h04, 8'hDE, 0, 8'h00, 8'hA5};
    vt[4] = '{0, 0, 8'hFF, 8'hDE, 1, 8'h81, 8'h81};
    vt[5] = '{0, 1, 8'h00, 8'h00, 0, 8'h00, 8'h00};
    vt[6] = '{1, 0, 8'h20, 8'hDE, 0, 8'h00, 8'h77};
    vt[7] = '{1, 1, 8'hFF, 8'hFF, 0, 8'h00, 8'h00};
    vt[8] = '{1, 0, 8'hFF, 8'hDE, 0, 8'h00, 8'hFF};
    vt[9] = '{0, 0, 8'h00, 8'hDE, 0, 8'h00, 8'h00};

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst = 1'b1;
    drive(0, 0, 0, 8'h00, 8'h00);
    drive(1, 0, 0, 8'h00, 8'h00);
    rst_dut();

    for (int i = 0; i < 10; i++) do_txn(vt[i], 1'b0);

    // Request dropped right after being sampled still completes.
    v = '{1, 0, 8'h11, 8'h00, 0, 8'h00, 8'h3C};
    do_txn(v, 1'b1);

    // Address/data churn during ACCESS must not leak in.
    @(posedge clk); #1;
    push(0, 1, 8'h04, 8'h5C, 8'h00);
    drive(0, 1, 1, 8'h04, 8'h5C);
    seen = 0;
    got  = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (seen) chk("churn_addr", reg_addr, 8'h04);
      if (reg_cs) begin
        seen = 1;
        drive(0, 1, 0, 8'h07, 8'h00);
      end
      if (ack0) begin
        chk("churn_wdata", reg_wdata, 8'h5C);
        got = 1;
        break;
      end
    end
    set_req(0, 1'b0);
    chk("churn_ack", got, 1);

    // Reset in the cycle after reg_cs of a read.
    @(posedge clk); #1;
    mem[8'h30] = 8'h5A;
    push(0, 0, 8'h30, 8'h00, 8'h5A);
    drive(0, 1, 0, 8'h30, 8'h00);
    seen = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (reg_cs) begin
        seen = 1;
        break;
      end
    end
    chk("mid_cs_seen", seen, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    q.delete();
    mdl[0] = 8'h00;
    mdl[1] = 8'h00;
    @(negedge clk);
    chk_rst();
    rst = 1'b0;
    push(0, 0, 8'h30, 8'h00, 8'h5A);
    got = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ack0) begin
        got = k;
        break;
      end
    end
    set_req(0, 1'b0);
    chk("mid_reread_ack", got, 3);

    // Tie right after reset: grants alternate 0,1,0,1.
    rst_dut();
    @(posedge clk); #1;
    push(0, 1, 8'h01, 8'h10, 8'h00);
    push(1, 1, 8'h02, 8'h20, 8'h00);
    push(0, 1, 8'h01, 8'h10, 8'h00);
    push(1, 1, 8'h02, 8'h20, 8'h00);
    drive(0, 1, 1, 8'h01, 8'h10);
    drive(1, 1, 1, 8'h02, 8'h20);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ack0 || ack1) n++;
      if (n == 4) break;
    end
    set_req(0, 1'b0);
    set_req(1, 1'b0);
    chk("tie_acks", n, 4);
    repeat (3) @(negedge clk);
    chk("tie_drain", q.size(), 0);

    // Port 0 holds req for three writes back to back.
    @(posedge clk); #1;
    base = cs_cnt;
    for (int i = 0; i < 3; i++) push(0, 1, 8'h08, 8'hC3, 8'h00);
    drive(0, 1, 1, 8'h08, 8'hC3);
    n = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (ack0) begin
        t[n] = cyc;
        n++;
      end
      if (n == 3) break;
    end
    set_req(0, 1'b0);
    chk("b2b_acks", n, 3);
    if (n == 3) begin
      chk("b2b_gap1", t[1] - t[0], 3);
      chk("b2b_gap2", t[2] - t[1], 3);
    end
    repeat (3) @(negedge clk);
    chk("b2b_cs_count", cs_cnt - base, 3);
    chk("b2b_drain", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
